// File: rtl/arbiter_pkg.sv
// Shared types and helpers for the N-way request/grant arbiter.
package arbiter_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

  typedef enum logic [0:0] {
    ARB_FIXED = 1'b0,
    ARB_RR    = 1'b1
  } arb_mode_e;

  // Hold counter width; a disabled limit still needs one bit.
  function automatic int unsigned hold_width(input int unsigned max_hold);
    return (max_hold == 0) ? 1 : $clog2(max_hold + 1);
  endfunction

endpackage

// File: rtl/arbiter_pick.sv
// Combinational winner selection: first set request at or above base_i, wrapping.
module arbiter_pick #(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned ID_W  = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req_i,
  input  logic [ID_W-1:0]  base_i,
  output logic             found_o,
  output logic [ID_W-1:0]  idx_o
);

  logic [N_REQ-1:0] rot;
  logic [ID_W:0]    off;
  logic [ID_W:0]    sum;

  always_comb begin
    // Rotating the doubled vector puts base_i at bit 0.
    rot     = N_REQ'({req_i, req_i} >> base_i);
    found_o = |rot;
    off     = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (rot[i]) off = (ID_W+1)'(i);
    end
    sum = off + {1'b0, base_i};
    if (sum >= (ID_W+1)'(N_REQ)) sum = sum - (ID_W+1)'(N_REQ);
    idx_o = sum[ID_W-1:0];
  end

endmodule

// File: rtl/arbiter_rr.sv
// N-way registered arbiter: fixed-priority or round-robin, grant held while requested,
// optional hold limit that preempts a long-running owner when others are waiting.
module arbiter_rr
  import arbiter_pkg::*;
#(
  parameter int unsigned N_REQ    = 4,
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned ID_W     = $clog2(N_REQ),
  parameter int unsigned HOLD_W   = hold_width(MAX_HOLD)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [N_REQ-1:0] req_i,
  input  logic             mode_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic             gnt_valid_o,
  output logic [ID_W-1:0]  gnt_id_o,
  output logic             preempt_o
);

  arb_state_t        state_q, state_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              gnt_valid_q, gnt_valid_d;
  logic [ID_W-1:0]   gnt_id_q, gnt_id_d;
  logic              preempt_q, preempt_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
  logic [N_REQ-1:0]  excl_mask_q, excl_mask_d;

  logic [N_REQ-1:0] masked_req;
  logic [N_REQ-1:0] others_req;
  logic [ID_W-1:0]  pick_base;
  logic [ID_W-1:0]  pick_idx;
  logic             pick_found;

  assign masked_req = req_i & ~excl_mask_q;
  assign pick_base  = (arb_mode_e'(mode_i) == ARB_RR) ? rr_ptr_q : '0;
  // gnt_q is one-hot of the owner, so this is every requester except the owner.
  assign others_req = req_i & ~gnt_q;

  arbiter_pick #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_pick (
    .req_i   (masked_req),
    .base_i  (pick_base),
    .found_o (pick_found),
    .idx_o   (pick_idx)
  );

  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_valid_d = gnt_valid_q;
    gnt_id_d    = gnt_id_q;
    preempt_d   = 1'b0;
    rr_ptr_d    = rr_ptr_q;
    hold_cnt_d  = hold_cnt_q;
    excl_mask_d = excl_mask_q;

    unique case (state_q)
      IDLE: begin
        excl_mask_d = '0;
        if (pick_found) begin
          state_d     = GRANT;
          gnt_d       = {{(N_REQ-1){1'b0}}, 1'b1} << pick_idx;
          gnt_valid_d = 1'b1;
          gnt_id_d    = pick_idx;
          hold_cnt_d  = HOLD_W'(1);
          rr_ptr_d    = (pick_idx == ID_W'(N_REQ - 1)) ? '0 : pick_idx + ID_W'(1);
        end
      end
      GRANT: begin
        if (!req_i[gnt_id_q]) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
        end else if ((MAX_HOLD != 0) && (hold_cnt_q == HOLD_W'(MAX_HOLD)) && (|others_req)) begin
          state_d     = IDLE;
          gnt_d       = '0;
          gnt_valid_d = 1'b0;
          preempt_d   = 1'b1;
          excl_mask_d = gnt_q;
        end else if ((MAX_HOLD != 0) && (hold_cnt_q < HOLD_W'(MAX_HOLD))) begin
          hold_cnt_d = hold_cnt_q + HOLD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_valid_q <= 1'b0;
      gnt_id_q    <= '0;
      preempt_q   <= 1'b0;
      rr_ptr_q    <= '0;
      hold_cnt_q  <= '0;
      excl_mask_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_valid_q <= gnt_valid_d;
      gnt_id_q    <= gnt_id_d;
      preempt_q   <= preempt_d;
      rr_ptr_q    <= rr_ptr_d;
      hold_cnt_q  <= hold_cnt_d;
      excl_mask_q <= excl_mask_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_valid_o = gnt_valid_q;
  assign gnt_id_o    = gnt_id_q;
  assign preempt_o   = preempt_q;

endmodule

// File: tb/tb_arbiter_rr.sv
// Bench for arbiter_rr: vector table, directed corner cases and random traffic vs a model.
module tb_arbiter_rr;

  localparam int NReq    = 4;
  localparam int MaxHold = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [3:0] req;
  logic       mode;

  logic [3:0] gnt, gnt_nl;
  logic       gnt_valid, gnt_valid_nl;
  logic [1:0] gnt_id, gnt_id_nl;
  logic       preempt, preempt_nl;

  int n_chk  = 0;
  int n_fail = 0;

  // Reference model state, in requester numbers rather than encodings.
  int m_owner, m_held, m_ptr, m_excl, m_gid;
  bit m_pre;

  always #5 clk = ~clk;

  arbiter_rr #(
    .N_REQ    (4),
    .MAX_HOLD (4)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .mode_i      (mode),
    .gnt_o       (gnt),
    .gnt_valid_o (gnt_valid),
    .gnt_id_o    (gnt_id),
    .preempt_o   (preempt)
  );

  arbiter_rr #(
    .N_REQ    (4),
    .MAX_HOLD (0)
  ) dut_nolim (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .req_i       (req),
    .mode_i      (mode),
    .gnt_o       (gnt_nl),
    .gnt_valid_o (gnt_valid_nl),
    .gnt_id_o    (gnt_id_nl),
    .preempt_o   (preempt_nl)
  );

  typedef struct {
    logic [3:0] req;
    logic       mode;
    logic [3:0] gnt;
    logic [1:0] id;
    logic       pre;
  } vec_t;

  vec_t vecs[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_ptr   = 0;
    m_excl  = -1;
    m_gid   = 0;
    m_pre   = 1'b0;
  endtask

  task automatic model_edge();
    int w;
    int base;
    int idx;
    m_pre = 1'b0;
    if (m_owner < 0) begin
      base = mode ? m_ptr : 0;
      w    = -1;
      for (int k = 0; k < NReq; k++) begin
        idx = (base + k) % NReq;
        if (w < 0 && req[idx] && idx != m_excl) w = idx;
      end
      m_excl = -1;
      if (w >= 0) begin
        m_owner = w;
        m_gid   = w;
        m_held  = 1;
        m_ptr   = (w + 1) % NReq;
      end
    end else if (!req[m_owner]) begin
      m_owner = -1;
    end else if (MaxHold != 0 && m_held >= MaxHold && (req & ~(4'b0001 << m_owner)) != 4'b0) begin
      m_pre   = 1'b1;
      m_excl  = m_owner;
      m_owner = -1;
    end else begin
      m_held++;
    end
  endtask

  task automatic model_check();
    logic [3:0] exp_g;
    exp_g = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
    chk("gnt", gnt, exp_g);
    chk("gnt_valid", gnt_valid, (m_owner >= 0));
    chk("gnt_id", gnt_id, m_gid);
    chk("preempt", preempt, m_pre);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    model_check();
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst_n = 1'b0;
    req   = 4'b0000;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  always @(negedge clk) begin
    chk("onehot0", $onehot0(gnt), 1);
    chk("valid_or", gnt_valid, |gnt);
    chk("onehot0_nolim", $onehot0(gnt_nl), 1);
    chk("valid_or_nolim", gnt_valid_nl, |gnt_nl);
  end

  initial begin
    int pre_cnt;
    int p;
    int g;
    logic [3:0] exp_g;

    vecs[0]  = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0};
    vecs[1]  = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0};
    vecs[2]  = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0};
    vecs[3]  = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0};
    vecs[4]  = '{4'b1010, 1'b0, 4'b0000, 2'd1, 1'b1};
    vecs[5]  = '{4'b1010, 1'b0, 4'b1000, 2'd3, 1'b0};
    vecs[6]  = '{4'b1010, 1'b0, 4'b1000, 2'd3, 1'b0};
    vecs[7]  = '{4'b1010, 1'b0, 4'b1000, 2'd3, 1'b0};
    vecs[8]  = '{4'b1010, 1'b0, 4'b1000, 2'd3, 1'b0};
    vecs[9]  = '{4'b1010, 1'b0, 4'b0000, 2'd3, 1'b1};
    vecs[10] = '{4'b1010, 1'b0, 4'b0010, 2'd1, 1'b0};
    vecs[11] = '{4'b1001, 1'b0, 4'b0000, 2'd1, 1'b0};
    vecs[12] = '{4'b1001, 1'b0, 4'b0001, 2'd0, 1'b0};
    vecs[13] = '{4'b1000, 1'b0, 4'b0000, 2'd0, 1'b0};
    vecs[14] = '{4'b1000, 1'b0, 4'b1000, 2'd3, 1'b0};
    vecs[15] = '{4'b1001, 1'b0, 4'b1000, 2'd3, 1'b0};
    vecs[16] = '{4'b1001, 1'b1, 4'b1000, 2'd3, 1'b0};
    vecs[17] = '{4'b1001, 1'b0, 4'b1000, 2'd3, 1'b0};
    vecs[18] = '{4'b0001, 1'b0, 4'b0000, 2'd3, 1'b0};
    vecs[19] = '{4'b0001, 1'b0, 4'b0001, 2'd0, 1'b0};

    rst_n = 1'b0;
    req   = 4'b0000;
    mode  = 1'b0;
    model_reset();
    #12;
    chk("rst_gnt", gnt, 4'b0000);
    chk("rst_valid", gnt_valid, 1'b0);
    chk("rst_id", gnt_id, 2'd0);
    chk("rst_preempt", preempt, 1'b0);
    rst_n = 1'b1;

    // Fixed priority with exclusion, release latency, release beating the hold limit.
    for (int i = 0; i < 20; i++) begin
      req  = vecs[i].req;
      mode = vecs[i].mode;
      tick();
      chk($sformatf("tbl%0d_gnt", i), gnt, vecs[i].gnt);
      chk($sformatf("tbl%0d_id", i), gnt_id, vecs[i].id);
      chk($sformatf("tbl%0d_valid", i), gnt_valid, (vecs[i].gnt != 4'b0));
      chk($sformatf("tbl%0d_pre", i), preempt, vecs[i].pre);
    end

    // Asynchronous reset mid-grant.
    reset_dut();
    mode = 1'b0;
    req  = 4'b0100;
    tick();
    chk("ar_grant", gnt, 4'b0100);
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_gnt_drop", gnt, 4'b0000);
    chk("ar_valid_drop", gnt_valid, 1'b0);
    model_reset();
    @(posedge clk);
    #1;
    chk("ar_held", gnt, 4'b0000);
    #2;
    rst_n = 1'b1;
    req   = 4'b0001;
    #1;
    chk("ar_no_edge", gnt, 4'b0000);
    tick();
    chk("ar_regrant", gnt, 4'b0001);

    // Round-robin with all requesting: 4 grant cycles then one preempt/idle cycle.
    reset_dut();
    mode    = 1'b1;
    req     = 4'b1111;
    pre_cnt = 0;
    for (int k = 1; k <= 25; k++) begin
      tick();
      p     = (k - 1) % 5;
      g     = ((k - 1) / 5) % 4;
      exp_g = (p < 4) ? (4'b0001 << g) : 4'b0000;
      chk($sformatf("rr%0d_gnt", k), gnt, exp_g);
      chk($sformatf("rr%0d_pre", k), preempt, (p == 4));
      if (preempt) pre_cnt++;
    end
    chk("rr_preempt_count", pre_cnt, 5);

    // Lone requester is never preempted.
    reset_dut();
    mode = 1'b0;
    req  = 4'b0100;
    for (int k = 0; k < 12; k++) begin
      tick();
      chk("lone_gnt", gnt, 4'b0100);
      chk("lone_pre", preempt, 1'b0);
    end

    // Hold limit disabled: requester 0 keeps the grant despite requester 2 waiting.
    reset_dut();
    req = 4'b0101;
    for (int k = 0; k < 20; k++) begin
      tick();
      chk("nolim_gnt", gnt_nl, 4'b0001);
      chk("nolim_pre", preempt_nl, 1'b0);
    end

    // Random traffic against the model.
    reset_dut();
    for (int k = 0; k < 1500; k++) begin
      if ($urandom_range(3) == 0) req = 4'($urandom);
      if ($urandom_range(15) == 0) mode = ~mode;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
